mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 25 ++
 rtl/arb_picker.sv | 49 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter slice.
//   MIPS_ADDR_W / MIPS_DATA_W : default word-address and data widths of the shared memory_unit
//   owner_t                   : registered owner of the access issued last cycle
//   src_t                     : which requester received the most recent grant
//   GNT_IF / GNT_D            : bit positions inside the one-hot grant vector
package mips_pkg;

    localparam int unsigned MIPS_ADDR_W = 8;
    localparam int unsigned MIPS_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_IF,
        OWN_D
    } owner_t;

    typedef enum logic {
        SRC_IF,
        SRC_D
    } src_t;

    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_D  = 1;

endpackage

// File: rtl/arb_picker.sv
// Conflict resolution between the fetch and data requesters.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on a conflict, grant the requester that did not win last time
//   undefined : fixed priority, the data side always wins a conflict
// Ports:
//   if_req     in   fetch request (already qualified by reset)
//   d_req      in   data request (already qualified by reset)
//   last_grant in   requester that received the most recent grant
//   grant      out  one-hot grant, bit GNT_IF = fetch, bit GNT_D = data
module arb_picker
    import mips_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  src_t       last_grant,
    output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = 2'b00;
        if (if_req && d_req) begin
            if (last_grant == SRC_D) begin
                grant[GNT_IF] = 1'b1;
            end else begin
                grant[GNT_D] = 1'b1;
            end
        end else if (if_req) begin
            grant[GNT_IF] = 1'b1;
        end else if (d_req) begin
            grant[GNT_D] = 1'b1;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 2'b00;
        if (d_req) begin
            grant[GNT_D] = 1'b1;
        end else if (if_req) begin
            grant[GNT_IF] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of one single-port memory
// with a fixed one-cycle read latency. Grants are combinational in the request cycle,
// the response appears one cycle later, and back-to-back accesses pipeline freely.
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin on conflict; fixed data priority
// when undefined), resolved inside arb_picker.
// Ports:
//   clk, clr                         clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt         fetch request and same-cycle grant
//   if_rvalid/if_rdata               fetch read response
//   d_req/d_we/d_addr/d_wdata        data request; d_gnt same-cycle grant
//   d_rvalid/d_rdata                 data read response or write acknowledge
//   mem_en/mem_wen/mem_addr/mem_wdata memory command from the granted requester
//   mem_rdata                        memory read data, one cycle after the access
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = MIPS_ADDR_W,
    parameter int unsigned DATA_W = MIPS_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_t     owner_q, owner_d;
    src_t       last_grant_q, last_grant_d;
    logic       d_we_q, d_we_d;
    logic [1:0] grant;

    // Requests are masked by clr so nothing can be granted while in reset.
    arb_picker u_arb_picker (
        .if_req     (if_req && !clr),
        .d_req      (d_req && !clr),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign if_gnt = grant[GNT_IF];
    assign d_gnt  = grant[GNT_D];

    // Memory command, zeroed when nobody is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_wen   = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Owner records last cycle's grant; d_we_q tells a write ack from a read.
    always_comb begin
        owner_d      = OWN_IDLE;
        last_grant_d = last_grant_q;
        d_we_d       = 1'b0;
        if (if_gnt) begin
            owner_d      = OWN_IF;
            last_grant_d = SRC_IF;
        end else if (d_gnt) begin
            owner_d      = OWN_D;
            last_grant_d = SRC_D;
            d_we_d       = d_we;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            owner_q      <= OWN_IDLE;
            last_grant_q <= SRC_D;
            d_we_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            d_we_q       <= d_we_d;
        end
    end

    // clr also suppresses a response already in flight.
    always_comb begin
        if_rvalid = (owner_q == OWN_IF) && !clr;
        d_rvalid  = (owner_q == OWN_D) && !clr;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !d_we_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a scoreboard of expected responses.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    bit          started = 1'b0;
    bit          ram_load = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: one-cycle read latency.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] model_mem [256];

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= model_mem[i];
        end else if (mem_en) begin
            if (mem_wen) ram[mem_addr] <= mem_wdata;
            else         mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        bit            is_d;
        logic [DW-1:0] data;
        int unsigned   due;
    } resp_t;

    resp_t q[$];

    // Model of arbitration history: 1 = data side won most recently.
    bit m_last_d = 1'b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the combinational grant and memory command.
    task automatic cycle(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd, input bit c,
                         output bit g_if, output bit g_d);
        @(posedge clk);
        #1;
        clr = c; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        started = 1'b1;
        @(negedge clk);
        g_if = 1'b0;
        g_d  = 1'b0;
        if (!c) begin
            if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m_last_d) g_if = 1'b1; else g_d = 1'b1;
`else
                g_d = 1'b1;
`endif
            end else begin
                g_if = ir;
                g_d  = dr;
            end
        end
        chk("if_gnt", 32'(if_gnt), 32'(g_if));
        chk("d_gnt", 32'(d_gnt), 32'(g_d));
        chk("mem_en", 32'(mem_en), 32'(g_if | g_d));
        chk("mem_wen", 32'(mem_wen), 32'(g_d & dwe));
        chk("mem_addr", 32'(mem_addr), g_d ? 32'(da) : g_if ? 32'(ia) : 32'd0);
        chk("mem_wdata", mem_wdata, g_d ? dwd : 32'd0);
        if (c) m_last_d = 1'b1;
        if (g_if) begin
            q.push_back('{is_d: 1'b0, data: model_mem[ia], due: cyc + 1});
            m_last_d = 1'b0;
        end
        if (g_d) begin
            if (dwe) begin
                model_mem[da] = dwd;
                q.push_back('{is_d: 1'b1, data: '0, due: cyc + 1});
            end else begin
                q.push_back('{is_d: 1'b1, data: model_mem[da], due: cyc + 1});
            end
            m_last_d = 1'b1;
        end
    endtask

    // Response monitor: any response not due this cycle must be absent.
    always @(negedge clk) begin
        if (started) begin
            bit            e_if, e_d;
            logic [DW-1:0] e_ifd, e_dd;
            e_if = 1'b0; e_d = 1'b0; e_ifd = '0; e_dd = '0;
            if (clr) begin
                while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                resp_t r;
                r = q.pop_front();
                if (r.is_d) begin e_d = 1'b1; e_dd = r.data; end
                else        begin e_if = 1'b1; e_ifd = r.data; end
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_d));
            chk("if_rdata", if_rdata, e_ifd);
            chk("d_rdata", d_rdata, e_dd);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gi, gd;
        bit ip, dp, dwe;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        for (int i = 0; i < 256; i++) model_mem[i] = $urandom;

        // Reset (loads the memory image).
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 1, gi, gd);
        ram_load = 1'b0;

        // Lone fetch.
        cycle(1, 8'h04, 0, 0, 0, 0, 0, gi, gd);
        cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

        // Data write then read of the same word.
        cycle(0, 0, 1, 1, 8'h10, 32'hDEADBEEF, 0, gi, gd);
        cycle(0, 0, 1, 0, 8'h10, 0, 0, gi, gd);
        cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
        chk("rd_after_wr_model", model_mem[8'h10], 32'hDEADBEEF);

        // 4-cycle conflict straight after reset.
        cycle(0, 0, 0, 0, 0, 0, 1, gi, gd);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 8'h20, 1, 0, 8'h30, 0, 0, gi, gd);
`ifdef ARB_ROUND_ROBIN_EN
            chk("conflict_order", 32'(gd), 32'(k % 2));
`else
            chk("conflict_order", 32'(gd), 32'd1);
`endif
        end
        cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

        // Reset lands one cycle after a grant: response must vanish.
        cycle(1, 8'h05, 0, 0, 0, 0, 0, gi, gd);
        cycle(0, 0, 0, 0, 0, 0, 1, gi, gd);
        cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

        // Pipelined fetches.
        for (int k = 0; k < 4; k++) cycle(1, AW'(k), 0, 0, 0, 0, 0, gi, gd);

        // Idle.
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

        // Random traffic; requesters hold their request until granted.
        ip = 0; dp = 0; ia = '0; da = '0; dwe = 0; dwd = '0;
        for (int n = 0; n < 600; n++) begin
            bit c;
            if (!ip && $urandom_range(1, 0) == 1) begin
                ip = 1; ia = AW'($urandom_range(15, 0));
            end
            if (!dp && $urandom_range(1, 0) == 1) begin
                dp = 1; da = AW'($urandom_range(15, 0)); dwe = $urandom_range(1, 0) == 1;
                dwd = $urandom;
            end
            c = ($urandom_range(39, 0) == 0);
            cycle(ip, ia, dp, dwe, da, dwd, c, gi, gd);
            if (gi) ip = 0;
            if (gd) dp = 0;
        end

        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
